// File: rtl/bt_hdr_pkg.sv
// Shared constants and state encoding for the transmit header sequencer.
package bt_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HDR  = 2'd2,
    HEC  = 2'd3
  } hdr_state_e;

  localparam int HDR_INFO_BITS = 10;
  localparam int HEC_BITS      = 8;
  localparam int FEC_REP       = 3;
  localparam int LT_ADDR_W     = 3;
  localparam int TYPE_W        = 4;

  localparam logic [3:0] LAST_INFO_BIT = 4'(HDR_INFO_BITS - 1);
  localparam logic [3:0] LAST_HEC_BIT  = 4'(HEC_BITS - 1);
  localparam logic [1:0] LAST_REP      = 2'(FEC_REP - 1);

endpackage

// File: rtl/header_txseq.sv
// Header sequencer: latches header info on start, then walks 10 info bits and
// 8 HEC slots with each bit repeated over three 1 us symbols (FEC 1/3).
module header_txseq
  import bt_hdr_pkg::*;
(
  input  logic                 clk_6M,
  input  logic                 rstz,
  input  logic                 p_1us,
  input  logic                 start_p,
  input  logic                 abort_p,
  input  logic [LT_ADDR_W-1:0] lt_addr,
  input  logic [TYPE_W-1:0]    pk_type,
  input  logic                 flow,
  input  logic                 arqn,
  input  logic                 seqn,
  output logic                 header_st_p,
  output logic                 header_en,
  output logic                 hec_en,
  output logic                 fec31inc_p,
  output logic                 pkheader_bitin,
  output logic                 py_st_p,
  output logic                 busy
);

  hdr_state_e               state, state_nxt;
  logic [HDR_INFO_BITS-1:0] info, info_nxt;
  logic [3:0]               bit_cnt, bit_cnt_nxt;
  logic [1:0]               rep_cnt, rep_cnt_nxt;
  logic                     header_st_nxt, py_st_nxt;
  logic                     sym_last;

  // Final repetition of a bit ends on this p_1us; data stays put through it.
  assign sym_last = p_1us && (rep_cnt == LAST_REP) && ((state == HDR) || (state == HEC));

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state       <= IDLE;
      info        <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      header_st_p <= 1'b0;
      py_st_p     <= 1'b0;
    end else begin
      state       <= state_nxt;
      info        <= info_nxt;
      bit_cnt     <= bit_cnt_nxt;
      rep_cnt     <= rep_cnt_nxt;
      header_st_p <= header_st_nxt;
      py_st_p     <= py_st_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    info_nxt      = info;
    bit_cnt_nxt   = bit_cnt;
    rep_cnt_nxt   = rep_cnt;
    header_st_nxt = 1'b0;
    py_st_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start_p) begin
          info_nxt      = {seqn, arqn, flow, pk_type, lt_addr};
          header_st_nxt = 1'b1;
          bit_cnt_nxt   = '0;
          rep_cnt_nxt   = '0;
          state_nxt     = ARM;
        end
      end
      ARM: begin
        if (abort_p) begin
          state_nxt = IDLE;
        end else if (p_1us) begin
          bit_cnt_nxt = '0;
          rep_cnt_nxt = '0;
          state_nxt   = HDR;
        end
      end
      HDR, HEC: begin
        if (abort_p) begin
          bit_cnt_nxt = '0;
          rep_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (p_1us) begin
          if (rep_cnt != LAST_REP) begin
            rep_cnt_nxt = rep_cnt + 2'd1;
          end else begin
            rep_cnt_nxt = '0;
            if (state == HDR && bit_cnt == LAST_INFO_BIT) begin
              bit_cnt_nxt = '0;
              state_nxt   = HEC;
            end else if (state == HEC && bit_cnt == LAST_HEC_BIT) begin
              bit_cnt_nxt = '0;
              py_st_nxt   = 1'b1;
              state_nxt   = IDLE;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign header_en      = (state == HDR);
  assign hec_en         = (state == HEC);
  assign busy           = (state != IDLE);
  assign fec31inc_p     = sym_last;
  // HEC bit value is inserted by headerpro, so only info bits are driven here.
  assign pkheader_bitin = (state == HDR) ? info[bit_cnt] : 1'b0;

endmodule

// File: tb/tb_header_txseq.sv
// Directed self-checking bench for header_txseq.
`timescale 1ns/1ps
module tb_header_txseq;

  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic       p_1us = 1'b0, start_p = 1'b0, abort_p = 1'b0;
  logic [2:0] lt_addr = '0;
  logic [3:0] pk_type = '0;
  logic       flow = 1'b0, arqn = 1'b0, seqn = 1'b0;
  logic       header_st_p, header_en, hec_en, fec31inc_p, pkheader_bitin, py_st_p, busy;

  int checks = 0, errors = 0;
  int div = 0, cyc_n = 0;
  int n_hst, n_py, n_fec, n_hen, n_hec, n_sym, hec_p, first_hen, py_cyc, n0;
  logic [29:0] sym;
  logic s_hst, s_hen, s_hec, s_fec, s_bit, s_py, s_busy;

  localparam logic [29:0] SYM_BASIC = 30'b111000111000000111000111000111;
  localparam logic [29:0] SYM_B     = 30'b000111000111000000111000111000;

  header_txseq dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .start_p(start_p), .abort_p(abort_p),
    .lt_addr(lt_addr), .pk_type(pk_type), .flow(flow), .arqn(arqn), .seqn(seqn),
    .header_st_p(header_st_p), .header_en(header_en), .hec_en(hec_en),
    .fec31inc_p(fec31inc_p), .pkheader_bitin(pkheader_bitin), .py_st_p(py_st_p), .busy(busy)
  );

  always #83 clk_6M = ~clk_6M;

  task clr();
    n_hst = 0; n_py = 0; n_fec = 0; n_hen = 0; n_hec = 0; n_sym = 0; hec_p = 0;
    first_hen = -1; py_cyc = -1; sym = '0;
  endtask

  task sample();
    s_hst = header_st_p; s_hen = header_en; s_hec = hec_en; s_fec = fec31inc_p;
    s_bit = pkheader_bitin; s_py = py_st_p; s_busy = busy;
  endtask

  // One clock: drive inputs after the falling edge, sample mid-low-phase.
  task cyc(input logic st, input logic ab);
    @(negedge clk_6M);
    p_1us = (div == 5);
    div = (div == 5) ? 0 : div + 1;
    start_p = st; abort_p = ab;
    #40;
    sample();
    cyc_n++;
    if (s_hst) n_hst++;
    if (s_fec) n_fec++;
    if (s_py) begin n_py++; py_cyc = cyc_n; end
    if (s_hen) begin
      n_hen++;
      if (first_hen < 0) first_hen = cyc_n;
      if (p_1us) begin sym = {sym[28:0], s_bit}; n_sym++; end
    end
    if (s_hec) begin n_hec++; if (p_1us) hec_p++; end
  endtask

  // sel 0: symbols seen, 1: HEC p_1us seen, 2: fec pulses, 3: py pulses
  task wait_for(input int sel, input int val, input int maxc, input string nm);
    int k, m;
    k = 0;
    m = 0;
    while (m < val && k < maxc) begin
      cyc(1'b0, 1'b0);
      k++;
      m = (sel == 0) ? n_sym : (sel == 1) ? hec_p : (sel == 2) ? n_fec : n_py;
    end
    checks++;
    if (m < val) begin errors++; $display("FAIL %s timeout: got %0d want %0d", nm, m, val); end
  endtask

  task set_fields(input logic [2:0] la, input logic [3:0] ty, input logic f, input logic a, input logic s);
    lt_addr = la; pk_type = ty; flow = f; arqn = a; seqn = s;
  endtask

  task check_idle_outs(input string nm);
    checks++;
    if ({s_hst, s_hen, s_hec, s_fec, s_bit, s_py, s_busy} !== 7'b0) begin
      errors++;
      $display("FAIL %s outputs got %b want 0000000", nm, {s_hst, s_hen, s_hec, s_fec, s_bit, s_py, s_busy});
    end
  endtask

  task test_reset();
    rstz = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    check_idle_outs("reset");
    rstz = 1'b1;
    repeat (4) cyc(1'b0, 1'b0);
    check_idle_outs("post_reset_idle");
  endtask

  task test_basic();
    set_fields(3'b101, 4'b0100, 1'b1, 1'b0, 1'b1);
    clr();
    cyc(1'b1, 1'b0);
    n0 = cyc_n;
    checks++;
    if (s_hst !== 1'b0) begin errors++; $display("FAIL basic hst_early got %b want 0", s_hst); end
    cyc(1'b0, 1'b0);
    checks++;
    if ({s_hst, s_busy} !== 2'b11) begin errors++; $display("FAIL basic hst_latency got %b want 11", {s_hst, s_busy}); end
    wait_for(3, 1, 500, "basic_py");
    checks++;
    if (sym !== SYM_BASIC) begin errors++; $display("FAIL basic symbols got %b want %b", sym, SYM_BASIC); end
    checks++;
    if (n_sym != 30) begin errors++; $display("FAIL basic n_sym got %0d want 30", n_sym); end
    checks++;
    if (n_hen != 180) begin errors++; $display("FAIL basic header_en_cycles got %0d want 180", n_hen); end
    checks++;
    if (n_hec != 144) begin errors++; $display("FAIL basic hec_en_cycles got %0d want 144", n_hec); end
    checks++;
    if (n_fec != 18) begin errors++; $display("FAIL basic fec_pulses got %0d want 18", n_fec); end
    checks++;
    if (n_hst != 1) begin errors++; $display("FAIL basic hst_pulses got %0d want 1", n_hst); end
    checks++;
    if (py_cyc - first_hen != 324) begin errors++; $display("FAIL basic py_offset got %0d want 324", py_cyc - first_hen); end
    checks++;
    if ({s_hec, s_busy} !== 2'b00) begin errors++; $display("FAIL basic py_cycle_busy got %b want 00", {s_hec, s_busy}); end
    repeat (10) cyc(1'b0, 1'b0);
    checks++;
    if (n_py != 1) begin errors++; $display("FAIL basic py_pulses got %0d want 1", n_py); end
  endtask

  task test_start_on_p();
    while (div != 5) cyc(1'b0, 1'b0);
    clr();
    cyc(1'b1, 1'b0);
    n0 = cyc_n;
    cyc(1'b0, 1'b0);
    checks++;
    if ({s_hst, s_hen} !== 2'b10) begin errors++; $display("FAIL start_on_p hst got %b want 10", {s_hst, s_hen}); end
    wait_for(3, 1, 500, "start_on_p_py");
    checks++;
    if (first_hen - n0 != 7) begin errors++; $display("FAIL start_on_p first_sym got %0d want 7", first_hen - n0); end
    checks++;
    if (n_hen != 180) begin errors++; $display("FAIL start_on_p header_en_cycles got %0d want 180", n_hen); end
  endtask

  task test_start_busy();
    set_fields(3'b010, 4'b1001, 1'b0, 1'b1, 1'b0);
    clr();
    cyc(1'b1, 1'b0);
    wait_for(0, 9, 300, "busy_hdr");
    set_fields(3'b111, 4'b1111, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    wait_for(1, 5, 300, "busy_hec");
    cyc(1'b1, 1'b0);
    wait_for(3, 1, 500, "busy_py");
    repeat (20) cyc(1'b0, 1'b0);
    checks++;
    if (sym !== SYM_B) begin errors++; $display("FAIL start_busy symbols got %b want %b", sym, SYM_B); end
    checks++;
    if (n_hst != 1) begin errors++; $display("FAIL start_busy hst_pulses got %0d want 1", n_hst); end
    checks++;
    if (n_py != 1) begin errors++; $display("FAIL start_busy py_pulses got %0d want 1", n_py); end
    checks++;
    if (n_hec != 144) begin errors++; $display("FAIL start_busy hec_cycles got %0d want 144", n_hec); end
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL start_busy busy_after got %b want 0", s_busy); end
  endtask

  task test_abort();
    set_fields(3'b101, 4'b0100, 1'b1, 1'b0, 1'b1);
    clr();
    cyc(1'b1, 1'b0);
    wait_for(1, 10, 500, "abort_reach");
    while (div != 5) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    checks++;
    if ({s_hec, s_fec} !== 2'b10) begin errors++; $display("FAIL abort at_hec_b3r1 got %b want 10", {s_hec, s_fec}); end
    cyc(1'b0, 1'b0);
    check_idle_outs("abort_next");
    repeat (400) cyc(1'b0, 1'b0);
    checks++;
    if (n_py != 0) begin errors++; $display("FAIL abort py_pulses got %0d want 0", n_py); end
    clr();
    cyc(1'b1, 1'b0);
    wait_for(3, 1, 500, "abort_restart_py");
    checks++;
    if ({n_hen, n_hec} != {32'd180, 32'd144}) begin
      errors++; $display("FAIL abort restart hen/hec got %0d/%0d want 180/144", n_hen, n_hec);
    end
    checks++;
    if (py_cyc - first_hen != 324) begin errors++; $display("FAIL abort restart_len got %0d want 324", py_cyc - first_hen); end
  endtask

  task test_rst_mid();
    set_fields(3'b101, 4'b0100, 1'b1, 1'b0, 1'b1);
    clr();
    cyc(1'b1, 1'b0);
    wait_for(0, 4, 300, "rst_reach");
    @(negedge clk_6M);
    rstz = 1'b0;
    #5;
    sample();
    check_idle_outs("rst_async");
    repeat (2) cyc(1'b0, 1'b0);
    check_idle_outs("rst_hold");
    rstz = 1'b1;
    set_fields(3'b111, 4'b1111, 1'b1, 1'b1, 1'b1);
    clr();
    cyc(1'b1, 1'b0);
    wait_for(3, 1, 500, "rst_restart_py");
    checks++;
    if (sym !== 30'h3FFF_FFFF) begin errors++; $display("FAIL rst_mid symbols got %b want all ones", sym); end
    checks++;
    if (n_sym != 30) begin errors++; $display("FAIL rst_mid n_sym got %0d want 30", n_sym); end
  endtask

  task test_back_to_back();
    set_fields(3'b101, 4'b0100, 1'b1, 1'b0, 1'b1);
    clr();
    cyc(1'b1, 1'b0);
    wait_for(2, 18, 500, "b2b_first");
    set_fields(3'b010, 4'b1001, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    checks++;
    if (s_py !== 1'b1) begin errors++; $display("FAIL b2b py_cycle got %b want 1", s_py); end
    clr();
    cyc(1'b0, 1'b0);
    checks++;
    if ({s_hst, s_busy} !== 2'b11) begin errors++; $display("FAIL b2b hst got %b want 11", {s_hst, s_busy}); end
    wait_for(3, 1, 500, "b2b_second_py");
    checks++;
    if (sym !== SYM_B) begin errors++; $display("FAIL b2b symbols got %b want %b", sym, SYM_B); end
    checks++;
    if (n_fec != 18) begin errors++; $display("FAIL b2b fec_pulses got %0d want 18", n_fec); end
  endtask

  initial begin
    clr();
    test_reset();
    test_basic();
    test_start_on_p();
    test_start_busy();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
